bus_ready_controller: RTL

Wait-state and READY generator sitting directly downstream of the 8288-like bus controller. It watches the command strobes that controller produces, inserts a per-cycle-type number of wait states, and merges the synchronized I/O-channel-ready line. From these it drives the processor READY input. A watchdog releases READY if a peripheral holds the channel not-ready too long.

---
 rtl/bus_ready_pkg.sv | 40 ++++
 rtl/bus_ready_controller_if.sv | 27 ++
 rtl/bus_ready_sync.sv | 23 ++
 rtl/bus_ready_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bus_ready_pkg.sv
// Shared types and helpers for the bus READY / wait-state generator.
package bus_ready_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EXT   = 2'd2,
        HOLD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CYC_MEM  = 2'd0,
        CYC_IO   = 2'd1,
        CYC_INTA = 2'd2
    } cycle_e;

    // Interrupt acknowledge outranks I/O, which outranks memory.
    function automatic cycle_e decode_cycle(input logic i_inta_n,
                                            input logic i_ior_n,
                                            input logic i_iow_n);
        if (!i_inta_n)
            return CYC_INTA;
        else if (!i_ior_n || !i_iow_n)
            return CYC_IO;
        else
            return CYC_MEM;
    endfunction

    function automatic int unsigned select_wait(input cycle_e      i_cyc,
                                                input int unsigned i_mem_wait,
                                                input int unsigned i_io_wait,
                                                input int unsigned i_inta_wait);
        case (i_cyc)
            CYC_INTA: return i_inta_wait;
            CYC_IO:   return i_io_wait;
            default:  return i_mem_wait;
        endcase
    endfunction

endpackage

// File: rtl/bus_ready_controller_if.sv
// Command strobes from the bus controller and READY-side outputs toward the CPU.
interface bus_ready_controller_if;
    logic address_latch_enable;
    logic memory_read_command_n;
    logic memory_write_command_n;
    logic io_read_command_n;
    logic io_write_command_n;
    logic interrupt_acknowledge_n;
    logic io_channel_ready;
    logic processor_ready;
    logic wait_active;
    logic bus_timeout;

    modport master (
        output address_latch_enable, memory_read_command_n, memory_write_command_n,
               io_read_command_n, io_write_command_n, interrupt_acknowledge_n,
               io_channel_ready,
        input  processor_ready, wait_active, bus_timeout
    );

    modport slave (
        input  address_latch_enable, memory_read_command_n, memory_write_command_n,
               io_read_command_n, io_write_command_n, interrupt_acknowledge_n,
               io_channel_ready,
        output processor_ready, wait_active, bus_timeout
    );
endinterface

// File: rtl/bus_ready_sync.sv
// Two-flop synchronizer; resets to 1 so a not-yet-synchronized channel reads as ready.
module bus_ready_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);
    logic r_meta;
    logic r_sync;

    // Capture the asynchronous level and re-time it through a second flop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;
endmodule

// File: rtl/bus_ready_controller.sv
// Wait-state and READY generator behind the bus controller.
//   state | meaning
//   IDLE  | no cycle in progress, READY high
//   COUNT | inserting fixed wait states for the current cycle type
//   EXT   | waiting on the synchronized channel-ready, watchdog running
//   HOLD  | READY released, waiting for the command strobe to go away
module bus_ready_controller
    import bus_ready_pkg::*;
#(
    parameter int unsigned MEM_WAIT      = 0,
    parameter int unsigned IO_WAIT       = 1,
    parameter int unsigned INTA_WAIT     = 1,
    parameter int unsigned COUNT_WIDTH   = 4,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned TIMEOUT_WIDTH = 8
) (
    input logic                  clock,
    input logic                  reset,
    bus_ready_controller_if.slave bus
);
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [COUNT_WIDTH-1:0]   CNT_ONE   = COUNT_WIDTH'(1);

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [COUNT_WIDTH-1:0]   r_cnt;
    logic [COUNT_WIDTH-1:0]   w_cnt_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_wdog;
    logic [TIMEOUT_WIDTH-1:0] w_wdog_nxt;
    logic                     r_cmd_any_d;
    logic                     r_ready;
    logic                     r_timeout;
    logic                     w_ready_nxt;
    logic                     w_timeout_nxt;
    logic                     w_wait_active;
    logic                     w_cmd_any;
    logic                     w_cmd_start;
    logic                     w_abort;
    logic                     w_chrdy_s;
    cycle_e                   w_cyc;
    logic [COUNT_WIDTH-1:0]   w_wait_n;

    bus_ready_sync u_chrdy_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (bus.io_channel_ready),
        .o_sync  (w_chrdy_s)
    );

    assign w_cmd_any   = ~(bus.memory_read_command_n & bus.memory_write_command_n &
                           bus.io_read_command_n & bus.io_write_command_n &
                           bus.interrupt_acknowledge_n);
    assign w_cmd_start = w_cmd_any & ~r_cmd_any_d;
    assign w_abort     = ~w_cmd_any | bus.address_latch_enable;
    assign w_cyc       = decode_cycle(bus.interrupt_acknowledge_n, bus.io_read_command_n,
                                      bus.io_write_command_n);
    assign w_wait_n    = COUNT_WIDTH'(select_wait(w_cyc, MEM_WAIT, IO_WAIT, INTA_WAIT));

    // State, counters, edge-detect history and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wdog      <= '0;
            r_cmd_any_d <= 1'b0;
            r_ready     <= 1'b1;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wdog      <= w_wdog_nxt;
            r_cmd_any_d <= w_cmd_any;
            r_ready     <= w_ready_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next-state and counter update; an abort outranks every other exit from COUNT/EXT
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wdog_nxt  = r_wdog;
        case (r_state)
            IDLE: begin
                if (w_cmd_start) begin
                    if (w_wait_n != '0) begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = w_wait_n;
                    end else if (w_chrdy_s) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = EXT;
                        w_wdog_nxt  = '0;
                    end
                end
            end
            COUNT: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt <= CNT_ONE) begin
                    if (w_chrdy_s) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = EXT;
                        w_wdog_nxt  = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            EXT: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_chrdy_s || (r_wdog == WDOG_LAST)) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_wdog_nxt = r_wdog + TIMEOUT_WIDTH'(1);
                end
            end
            HOLD: begin
                if (!w_cmd_any)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: READY follows the next state so it moves on the same edge as the state
    always_comb begin
        w_ready_nxt   = (w_state_nxt == IDLE) || (w_state_nxt == HOLD);
        w_timeout_nxt = (r_state == EXT) && !w_abort && !w_chrdy_s && (r_wdog == WDOG_LAST);
        w_wait_active = (r_state == COUNT) || (r_state == EXT);
    end

    assign bus.processor_ready = r_ready;
    assign bus.wait_active     = w_wait_active;
    assign bus.bus_timeout     = r_timeout;
endmodule
